keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
Upstream front end of the microwave controller. Takes the raw 10-key keypad, then synchronises, debounces and encodes it. Digits are shifted into a 3-digit BCD entry buffer (M:ST:SO) that the countdown timer loads at start. It also reports per-keypress pulses for the control FSM.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive clock edges a key pattern must be stable, on both press and release; minimum 1.
CNT_W, 4, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clock  input  1  system clock, 100 Hz nominal (10 ms period)
clear  input  1  asynchronous active-high reset
key  input  10  raw keypad, key[i] high = digit i pressed, asynchronous and bouncy
enable  input  1  high = entry allowed (timer idle); low = buffer frozen
clr_entry  input  1  synchronous clear of the entry buffer (driven from the clear button)
digit_valid  output  1  one-cycle pulse per accepted debounced keypress
digit  output  4  BCD code of the last debounced key; held between pulses
reject  output  1  one-cycle pulse when a keypress is refused by the range check
min_bcd  output  4  minutes digit
sec_tens_bcd  output  4  seconds tens digit, always 0..5
sec_ones_bcd  output  4  seconds ones digit
entry_nonzero  output  1  combinational: high when any buffer digit is non-zero

Behaviour:
- Reset (clear=1, any time): FSM to IDLE, counter 0, synchroniser flops 0, all buffer digits 0, digit=0, digit_valid=0, reject=0. Reset takes effect immediately and is released on the next edge.
- key passes through a 2-flop synchroniser; ks denotes the stage-2 output.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
  - IDLE: if ks is one-hot, capture it to cap, set cnt=1, go to DEBOUNCE. If ks is zero or has multiple bits set, stay in IDLE.
  - DEBOUNCE: if ks!=cap, go to IDLE with cnt=0. Else if cnt==DEBOUNCE_CYCLES, go to HELD, register digit=encode(cap), and pulse digit_valid or reject. Else cnt++.
  - HELD: if ks==0, set cnt=1 and go to RELEASE. Otherwise stay, including when extra keys are added. No repeat pulses.
  - RELEASE: if ks!=0, return to HELD. Else if cnt==DEBOUNCE_CYCLES, go to IDLE. Else cnt++.
- Latency: with key stable from edge 1, ks is valid after edge 2 and the IDLE→DEBOUNCE transition happens at edge 3. digit_valid is registered high after edge DEBOUNCE_CYCLES+3; for the default of 3 that is edge 6. The buffer updates on the same edge as the pulse.
- Range check: a shift would move the old sec_ones into sec_tens. If old sec_ones>5, the keypress is refused: reject pulses instead of digit_valid, and the buffer is unchanged.
- Shift on an accepted press with enable=1:
  - min ← sec_tens
  - sec_tens ← sec_ones
  - sec_ones ← digit
  - the old min is discarded (wrap-around by shift-out).
- enable=0: the debounce FSM still runs and digit_valid/reject still pulse, but the buffer is frozen.
- clr_entry=1: all buffer digits are set to 0 on that edge. It wins over a shift in the same cycle; that press's digit_valid still pulses. The FSM is unaffected.
- Simultaneous keys: a multi-hot pattern in IDLE is ignored. A pattern change during DEBOUNCE aborts with no pulse.
- Encoding: one-hot index to 4-bit binary, key[0]→0 through key[9]→9.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, DEBOUNCE=1, HELD=2, RELEASE=3) and the BCD constant MAX_SEC_TENS=5.
- One sub-module, key_debounce, containing the synchroniser, FSM, counter and one-hot encoder. It outputs digit and a raw press pulse. The parent holds the range check and the shift buffer.

Test Plan:
1. Apply clear=1, then release it → all outputs 0 and entry_nonzero=0. Assert clear mid-DEBOUNCE → no pulse, FSM back to IDLE.
2. key=10'b0000010000 held for 10 cycles, then 0 → exactly one digit_valid at edge 6 with digit=4. Buffer reads 0:0:4 and entry_nonzero=1.
3. Press sequence 1, 3, 0 with releases between presses → buffer reads 1:3:0. Then press 7 → buffer reads 3:0:7 (the 1 is shifted out).
4. Buffer at 0:0:7, press 2 → reject pulse and buffer stays 0:0:7. Then clr_entry=1 → buffer 0:0:0. Then press 2 → buffer 0:0:2.
5. Bounce: key toggles 0↔bit0 every cycle for 6 cycles, then holds → a single digit_valid with digit=0 only after DEBOUNCE_CYCLES of stability. key=10'b0000000011 → no pulse.
6. enable=0, press 5 → digit_valid pulses with digit=5 but the buffer is unchanged. clr_entry on the same cycle as a shift → buffer 0:0:0.

Source files
------------

// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry front end.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package keypad_entry_pkg;

  // Debounce FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Largest legal seconds-tens digit; a shift that would exceed it is refused
  localparam logic [3:0] MAX_SEC_TENS = 4'd5;

  localparam int NUM_KEYS = 10;

  // Entry buffer, M:ST:SO, one BCD digit per field
  typedef struct packed {
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } entry_t;

  // True when exactly one key bit is set
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 10'd1)) == '0);
  endfunction

  // One-hot key index to 4-bit binary; only meaningful for one-hot input
  function automatic logic [3:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad-side and timer-side signals of the entry block bundled together.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are single-cycle and cannot be stalled.
interface keypad_entry_if;
  import keypad_entry_pkg::*;

  logic [NUM_KEYS-1:0] key;
  logic                enable;
  logic                clr_entry;
  logic                digit_valid;
  logic [3:0]          digit;
  logic                reject;
  logic [3:0]          min_bcd;
  logic [3:0]          sec_tens_bcd;
  logic [3:0]          sec_ones_bcd;
  logic                entry_nonzero;

  // Environment side: drives the keypad and control, observes the entry
  modport master (
    output key, enable, clr_entry,
    input  digit_valid, digit, reject,
    input  min_bcd, sec_tens_bcd, sec_ones_bcd, entry_nonzero
  );

  // Entry block side
  modport slave (
    input  key, enable, clr_entry,
    output digit_valid, digit, reject,
    output min_bcd, sec_tens_bcd, sec_ones_bcd, entry_nonzero
  );

endinterface

// File: rtl/keypad_entry_key_debounce.sv
// Synchronise, debounce and encode the raw 10-key keypad into one press strobe per key.
// Latency: press strobe is asserted DEBOUNCE_CYCLES+2 edges after the key settles.
// Backpressure: none; the strobe is combinational and the consumer must take it that cycle.
module key_debounce
  import keypad_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_KEYS-1:0] key,
  output logic                press,       // high for the cycle the FSM accepts a debounced key
  output logic [3:0]          press_code,  // encoded captured key, valid while press is high
  output logic [3:0]          digit        // registered code of the last debounced key
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] ks_q, ks_d;
  logic [NUM_KEYS-1:0] cap_q, cap_d;
  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          digit_q, digit_d;

  // The captured pattern is one-hot by construction, so it encodes directly
  assign press_code = onehot_to_bcd(cap_q);
  assign digit      = digit_q;

  // Two-stage synchroniser for the asynchronous keypad lines
  always_comb begin
    sync1_d = key;
    ks_d    = sync1_q;
  end

  // Debounce FSM: a pattern must hold for DEBOUNCE_CYCLES on press and on release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    digit_d = digit_q;
    press   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Idle with nothing or a chord on the pad: wait for a clean single key
        if (is_onehot(ks_q)) begin
          cap_d   = ks_q;
          cnt_d   = CNT_ONE;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (ks_q != cap_q) begin
          // Bounce or chord change: abandon this attempt silently
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          digit_d = press_code;
          press   = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        // No auto-repeat; extra keys added while held are ignored
        if (ks_q == '0) begin
          cnt_d   = CNT_ONE;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (ks_q != '0) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, synchroniser and digit registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync1_q <= '0;
      ks_q    <= '0;
      cap_q   <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      digit_q <= 4'd0;
    end else begin
      sync1_q <= sync1_d;
      ks_q    <= ks_d;
      cap_q   <= cap_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced digits shifted into the M:ST:SO entry buffer for the timer.
// Latency: digit_valid/reject and the buffer update land DEBOUNCE_CYCLES+3 edges after a stable key.
// Backpressure: none; each press yields exactly one single-cycle pulse, buffer frozen when enable is low.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = 4
) (
  input  logic           clock,
  input  logic           clear,
  keypad_entry_if.slave  bus
);

  logic       press;
  logic [3:0] press_code;
  logic [3:0] digit;
  logic       accept;

  entry_t entry_q, entry_d;
  logic   digit_valid_q, digit_valid_d;
  logic   reject_q, reject_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_key_debounce (
    .clock      (clock),
    .clear      (clear),
    .key        (bus.key),
    .press      (press),
    .press_code (press_code),
    .digit      (digit)
  );

  // A shift moves sec_ones into sec_tens, which must stay a valid seconds-tens digit
  assign accept = (entry_q.sec_ones <= MAX_SEC_TENS);

  // Range check, pulse generation and shift buffer next state
  always_comb begin
    entry_d       = entry_q;
    digit_valid_d = press & accept;
    reject_d      = press & ~accept;
    if (bus.clr_entry) begin
      // Clear beats a shift in the same cycle; the pulse itself is unaffected
      entry_d = '0;
    end else if (press && accept && bus.enable) begin
      // Oldest digit (minutes) falls off the top
      entry_d.min      = entry_q.sec_tens;
      entry_d.sec_tens = entry_q.sec_ones;
      entry_d.sec_ones = press_code;
    end
  end

  // Buffer and pulse registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      entry_q       <= '0;
      digit_valid_q <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      entry_q       <= entry_d;
      digit_valid_q <= digit_valid_d;
      reject_q      <= reject_d;
    end
  end

  assign bus.digit_valid   = digit_valid_q;
  assign bus.reject        = reject_q;
  assign bus.digit         = digit;
  assign bus.min_bcd       = entry_q.min;
  assign bus.sec_tens_bcd  = entry_q.sec_tens;
  assign bus.sec_ones_bcd  = entry_q.sec_ones;
  assign bus.entry_nonzero = (entry_q != '0);

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry with DEBOUNCE_CYCLES=3.
// Latency: expects pulses on edge 6 after a key is applied.
// Backpressure: n/a.
module tb_keypad_entry;

  logic clock = 1'b0;
  logic clear;
  int   vectors     = 0;
  int   miscompares = 0;

  keypad_entry_if bus();

  keypad_entry #(
    .DEBOUNCE_CYCLES (3),
    .CNT_W           (4)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Apply key for 10 edges then release for 10 edges, counting pulses.
  // clr_entry is asserted before edge clr_edge (0 = never). Called #1 after a posedge.
  task automatic do_press(input logic [9:0] k, input int clr_edge,
                          output int n_dv, output int n_rej, output int p_edge,
                          output logic [3:0] p_digit);
    n_dv = 0; n_rej = 0; p_edge = -1; p_digit = 4'hF;
    bus.key = k;
    for (int e = 1; e <= 20; e++) begin
      if (e == 11) bus.key = '0;
      bus.clr_entry = (e == clr_edge);
      @(posedge clock);
      #1;
      if (bus.digit_valid) begin n_dv++; p_edge = e; p_digit = bus.digit; end
      if (bus.reject) begin n_rej++; p_edge = e; p_digit = bus.digit; end
    end
    bus.clr_entry = 1'b0;
  endtask

  task automatic test_reset();
    int n_dv; int p_edge; logic [3:0] p_digit;
    clear = 1'b1; bus.key = '0; bus.enable = 1'b1; bus.clr_entry = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({bus.digit_valid, bus.reject, bus.digit, bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd, bus.entry_nonzero} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got dv=%b rej=%b dig=%0d buf=%0d:%0d:%0d nz=%b want all 0",
               bus.digit_valid, bus.reject, bus.digit, bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd, bus.entry_nonzero);
    end
    clear = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd, bus.entry_nonzero} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_release_buf got %0d:%0d:%0d nz=%b want 0:0:0 nz=0",
               bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd, bus.entry_nonzero);
    end
    // Key 4 held; clear strikes mid-debounce, then the FSM must restart from scratch
    bus.key = 10'b0000010000;
    repeat (4) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    vectors++;
    if (bus.digit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_debounce_dv got %b want 0", bus.digit_valid);
    end
    @(posedge clock);
    #1;
    clear = 1'b0;
    n_dv = 0; p_edge = -1; p_digit = 4'hF;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock);
      #1;
      if (bus.digit_valid) begin n_dv++; p_edge = e; p_digit = bus.digit; end
    end
    vectors++;
    if (n_dv !== 1 || p_edge !== 6 || p_digit !== 4'd4) begin
      miscompares++;
      $display("FAIL reset_restart got pulses=%0d edge=%0d digit=%0d want 1 at edge 6 digit 4", n_dv, p_edge, p_digit);
    end
    bus.key = '0;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd, bus.digit} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_again got buf=%0d:%0d:%0d dig=%0d want 0:0:0 dig 0",
               bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd, bus.digit);
    end
  endtask

  task automatic test_single_press();
    int n_dv; int n_rej; int p_edge; logic [3:0] p_digit;
    do_press(10'b0000010000, 0, n_dv, n_rej, p_edge, p_digit);
    vectors++;
    if (n_dv !== 1 || n_rej !== 0 || p_edge !== 6 || p_digit !== 4'd4) begin
      miscompares++;
      $display("FAIL single_pulse got dv=%0d rej=%0d edge=%0d digit=%0d want dv=1 rej=0 edge=6 digit=4",
               n_dv, n_rej, p_edge, p_digit);
    end
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h004 || bus.entry_nonzero !== 1'b1) begin
      miscompares++;
      $display("FAIL single_buf got %h nz=%b want 004 nz=1",
               {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd}, bus.entry_nonzero);
    end
  endtask

  task automatic test_shift_sequence();
    int n_dv; int n_rej; int p_edge; logic [3:0] p_digit;
    do_press(10'b0000000010, 0, n_dv, n_rej, p_edge, p_digit);
    do_press(10'b0000001000, 0, n_dv, n_rej, p_edge, p_digit);
    do_press(10'b0000000001, 0, n_dv, n_rej, p_edge, p_digit);
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h130) begin
      miscompares++;
      $display("FAIL shift_130 got %h want 130", {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd});
    end
    do_press(10'b0010000000, 0, n_dv, n_rej, p_edge, p_digit);
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h307 || n_dv !== 1 || p_digit !== 4'd7) begin
      miscompares++;
      $display("FAIL shift_out got %h dv=%0d digit=%0d want 307 dv=1 digit=7",
               {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd}, n_dv, p_digit);
    end
  endtask

  task automatic test_range_reject();
    int n_dv; int n_rej; int p_edge; logic [3:0] p_digit;
    bus.clr_entry = 1'b1;
    @(posedge clock);
    #1;
    bus.clr_entry = 1'b0;
    do_press(10'b0010000000, 0, n_dv, n_rej, p_edge, p_digit);
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h007) begin
      miscompares++;
      $display("FAIL range_setup got %h want 007", {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd});
    end
    do_press(10'b0000000100, 0, n_dv, n_rej, p_edge, p_digit);
    vectors++;
    if (n_rej !== 1 || n_dv !== 0 || p_edge !== 6 || p_digit !== 4'd2) begin
      miscompares++;
      $display("FAIL range_reject got rej=%0d dv=%0d edge=%0d digit=%0d want rej=1 dv=0 edge=6 digit=2",
               n_rej, n_dv, p_edge, p_digit);
    end
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h007) begin
      miscompares++;
      $display("FAIL range_frozen got %h want 007", {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd});
    end
    bus.clr_entry = 1'b1;
    @(posedge clock);
    #1;
    bus.clr_entry = 1'b0;
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h000 || bus.entry_nonzero !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_entry got %h nz=%b want 000 nz=0",
               {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd}, bus.entry_nonzero);
    end
    do_press(10'b0000000100, 0, n_dv, n_rej, p_edge, p_digit);
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h002 || n_dv !== 1 || n_rej !== 0) begin
      miscompares++;
      $display("FAIL range_after_clr got %h dv=%0d rej=%0d want 002 dv=1 rej=0",
               {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd}, n_dv, n_rej);
    end
  endtask

  task automatic test_bounce();
    int n_dv; int p_edge; logic [3:0] p_digit;
    n_dv = 0; p_edge = -1; p_digit = 4'hF;
    // Edges 1..6 toggle, key settles high before edge 7; clean restart sees it at edge 9
    for (int e = 1; e <= 16; e++) begin
      bus.key = (e <= 6 && e % 2 == 0) ? 10'b0000000000 : 10'b0000000001;
      @(posedge clock);
      #1;
      if (bus.digit_valid || bus.reject) begin n_dv++; p_edge = e; p_digit = bus.digit; end
    end
    vectors++;
    if (n_dv !== 1 || p_edge !== 12 || p_digit !== 4'd0) begin
      miscompares++;
      $display("FAIL bounce_pulse got pulses=%0d edge=%0d digit=%0d want 1 at edge 12 digit 0", n_dv, p_edge, p_digit);
    end
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h020) begin
      miscompares++;
      $display("FAIL bounce_buf got %h want 020", {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd});
    end
    bus.key = '0;
    repeat (10) @(posedge clock);
    #1;
    n_dv = 0;
    bus.key = 10'b0000000011;
    for (int e = 1; e <= 20; e++) begin
      if (e == 13) bus.key = '0;
      @(posedge clock);
      #1;
      if (bus.digit_valid || bus.reject) n_dv++;
    end
    vectors++;
    if (n_dv !== 0 || {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h020) begin
      miscompares++;
      $display("FAIL chord_ignored got pulses=%0d buf=%h want 0 pulses buf 020",
               n_dv, {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd});
    end
  endtask

  task automatic test_enable_gate();
    int n_dv; int n_rej; int p_edge; logic [3:0] p_digit;
    bus.enable = 1'b0;
    do_press(10'b0000100000, 0, n_dv, n_rej, p_edge, p_digit);
    vectors++;
    if (n_dv !== 1 || p_edge !== 6 || p_digit !== 4'd5 || bus.digit !== 4'd5) begin
      miscompares++;
      $display("FAIL disabled_pulse got dv=%0d edge=%0d digit=%0d held=%0d want dv=1 edge=6 digit=5 held=5",
               n_dv, p_edge, p_digit, bus.digit);
    end
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h020 || bus.entry_nonzero !== 1'b1) begin
      miscompares++;
      $display("FAIL disabled_frozen got %h nz=%b want 020 nz=1",
               {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd}, bus.entry_nonzero);
    end
    bus.enable = 1'b1;
    do_press(10'b1000000000, 6, n_dv, n_rej, p_edge, p_digit);
    vectors++;
    if (n_dv !== 1 || p_edge !== 6 || p_digit !== 4'd9) begin
      miscompares++;
      $display("FAIL clr_vs_shift_pulse got dv=%0d edge=%0d digit=%0d want dv=1 edge=6 digit=9", n_dv, p_edge, p_digit);
    end
    vectors++;
    if ({bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd} !== 12'h000 || bus.entry_nonzero !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_vs_shift_buf got %h nz=%b want 000 nz=0",
               {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd}, bus.entry_nonzero);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_shift_sequence();
    test_range_reject();
    test_bounce();
    test_enable_gate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
